// File: rtl/timing_nco_pkg.sv
// Shared definitions for the NCO timing controller.
//   lock_state_e : lock supervisor state encoding
//   calc_dw      : data word width from sign/integer/fraction bit counts
//   calc_one     : value of 1.0 in the fractional format
//   sat_clamp    : saturate a value into [lo, hi]
package timing_nco_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } lock_state_e;

  function automatic int unsigned calc_dw(input int unsigned sym_w,
                                          input int unsigned int_w,
                                          input int unsigned dec_w);
    return sym_w + int_w + dec_w;
  endfunction

  function automatic longint calc_one(input int unsigned dec_w);
    return longint'(1) << dec_w;
  endfunction

  function automatic longint sat_clamp(input longint x, input longint lo, input longint hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/dfflr.sv
// Register primitive: asynchronous active-high reset to zero, load enable.
//   clk  : clock
//   rst  : async reset, clears qout
//   lden : load enable
//   dnxt : next value
//   qout : registered value
module dfflr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lden,
  input  logic [W-1:0] dnxt,
  output logic [W-1:0] qout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/valid_delay_pipe.sv
// Shift-enabled delay line of D stages, W bits wide. Shifts only when en is
// high; D = 0 is a combinational pass-through.
//   clk, rst : clock and async active-high reset (stages clear to zero)
//   en       : shift enable
//   din      : value entering the line
//   dout     : value leaving the line (last stage)
module valid_delay_pipe #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (D == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, en};
    assign dout = din;
  end else begin : g_pipe
    logic [W-1:0] stage [D+1];
    assign stage[0] = din;
    for (genvar i = 1; i <= int'(D); i++) begin : g_stage
      dfflr #(.W(W)) u_ff (
        .clk  (clk),
        .rst  (rst),
        .lden (en),
        .dnxt (stage[i-1]),
        .qout (stage[i])
      );
    end
    assign dout = stage[D];
  end

endmodule

// File: rtl/timing_control_nco.sv
// NCO timing controller for the symbol-sync loop. A modulo-1 fractional
// register is decremented per input sample by the nominal step plus the
// clamped loop error; each underflow yields an interpolation strobe and the
// fractional interval mu, optionally delayed. A supervisor tracks the
// strobe interval and reports lock / alarm.
//   clk, rst   : clock, async active-high reset
//   in_valid   : new input sample; all state advances only when high
//   err_i      : signed loop-filter error
//   w_step_i   : signed nominal step (1 / samples-per-symbol)
//   freeze_i   : force error term to zero
//   strobe_o   : one-cycle symbol strobe
//   mu_o       : fractional interval, updated with strobe_o
//   lock_o     : supervisor in TRACK
//   alarm_o    : supervisor in ALARM
//   interval_o : samples between the last two underflows
module timing_control_nco
  import timing_nco_pkg::*;
#(
  parameter int unsigned SYM_WIDTH  = 1,
  parameter int unsigned INT_WIDTH  = 1,
  parameter int unsigned DEC_WIDTH  = 14,
  parameter int unsigned ERR_LIMIT  = 'h0400,
  parameter int unsigned STROBE_DLY = 2,
  parameter int unsigned MIN_SPS    = 2,
  parameter int unsigned MAX_SPS    = 16,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]     err_i,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0]     w_step_i,
  input  logic                                                freeze_i,
  output logic                                                strobe_o,
  output logic        [DEC_WIDTH-1:0]                         mu_o,
  output logic                                                lock_o,
  output logic                                                alarm_o,
  output logic        [CNT_W-1:0]                             interval_o
);

  localparam int unsigned DW      = calc_dw(SYM_WIDTH, INT_WIDTH, DEC_WIDTH);
  localparam int unsigned CW1     = CNT_W + 1;
  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam longint      ONE_L   = calc_one(DEC_WIDTH);
  localparam longint      ERR_L   = longint'(ERR_LIMIT);
  localparam longint      ETA_MIN = -(ONE_L - 1);
  localparam longint      ETA_MAX = (longint'(1) << (DW - 1)) - 1;

  localparam logic signed [DW-1:0]     ONE_S  = DW'(ONE_L);
  localparam logic        [CW1-1:0]    MIN_C  = CW1'(MIN_SPS);
  localparam logic        [CW1-1:0]    MAX_C  = CW1'(MAX_SPS);
  localparam logic        [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_CNT);

  // Phase accumulator
  logic signed [DW-1:0] eta_q, eta_mod, e_term, eta_nxt;

  // Arithmetic is widened to 64 bits before saturation; the ceiling only
  // guards against wrap-around on out-of-range inputs.
  always_comb begin
    eta_mod = eta_q[DW-1] ? eta_q + ONE_S : eta_q;
    e_term  = freeze_i ? '0 : DW'(sat_clamp(longint'(err_i), -ERR_L, ERR_L));
    eta_nxt = DW'(sat_clamp(longint'(eta_mod) - longint'(w_step_i) - longint'(e_term),
                            ETA_MIN, ETA_MAX));
  end

  dfflr #(.W(DW)) u_eta (
    .clk (clk), .rst (rst), .lden (in_valid), .dnxt (eta_nxt), .qout (eta_q)
  );

  logic                 wrap;
  logic [DEC_WIDTH-1:0] mu_raw;

  assign wrap   = in_valid & eta_q[DW-1];
  assign mu_raw = eta_mod[DEC_WIDTH-1:0];

  // Strobe delay line
  logic [DEC_WIDTH:0]   pipe_out;
  logic                 pipe_wrap;
  logic [DEC_WIDTH-1:0] pipe_mu;
  logic                 fire;

  valid_delay_pipe #(.W(DEC_WIDTH + 1), .D(STROBE_DLY)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  ({wrap, mu_raw}),
    .dout (pipe_out)
  );

  assign pipe_wrap = pipe_out[DEC_WIDTH];
  assign pipe_mu   = pipe_out[DEC_WIDTH-1:0];
  assign fire      = in_valid & pipe_wrap;

  dfflr #(.W(1)) u_strobe (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (fire), .qout (strobe_o)
  );

  dfflr #(.W(DEC_WIDTH)) u_mu (
    .clk (clk), .rst (rst), .lden (fire), .dnxt (pipe_mu), .qout (mu_o)
  );

  // Interval counter
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CW1-1:0]   cnt_inc;
  logic             legal, overrun;

  assign cnt_inc = {1'b0, cnt_q} + CW1'(1);
  assign legal   = (cnt_inc >= MIN_C) && (cnt_inc <= MAX_C);
  assign overrun = (cnt_inc > MAX_C);

  always_comb begin
    if (wrap) begin
      cnt_nxt = '0;
    end else if (&cnt_q) begin
      cnt_nxt = cnt_q;
    end else begin
      cnt_nxt = cnt_inc[CNT_W-1:0];
    end
  end

  dfflr #(.W(CNT_W)) u_cnt (
    .clk (clk), .rst (rst), .lden (in_valid), .dnxt (cnt_nxt), .qout (cnt_q)
  );

  dfflr #(.W(CNT_W)) u_interval (
    .clk (clk), .rst (rst), .lden (wrap), .dnxt (cnt_inc[CNT_W-1:0]), .qout (interval_o)
  );

  // Lock supervisor
  lock_state_e       state_q, state_nxt;
  logic [1:0]        state_bits;
  logic [GOOD_W-1:0] good_q, good_nxt, good_inc;

  assign state_q  = lock_state_e'(state_bits);
  assign good_inc = good_q + GOOD_W'(1);

  // A wrap is judged only by its own interval, so the overrun term applies
  // only on samples without a wrap.
  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_q;
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (wrap) state_nxt = TRACK;
        end
        TRACK: begin
          if ((wrap && !legal) || (!wrap && overrun)) state_nxt = ALARM;
        end
        ALARM: begin
          if (wrap && legal) begin
            if (good_inc == LOCK_C) begin
              state_nxt = TRACK;
              good_nxt  = '0;
            end else begin
              good_nxt = good_inc;
            end
          end else if (wrap || overrun) begin
            good_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  dfflr #(.W(2)) u_state (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (state_nxt), .qout (state_bits)
  );

  dfflr #(.W(GOOD_W)) u_good (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (good_nxt), .qout (good_q)
  );

  dfflr #(.W(1)) u_lock (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (state_nxt == TRACK), .qout (lock_o)
  );

  dfflr #(.W(1)) u_alarm (
    .clk (clk), .rst (rst), .lden (1'b1), .dnxt (state_nxt == ALARM), .qout (alarm_o)
  );

endmodule
